// File: rtl/sort4_stream_ctrl_pkg.sv
// ============================================================================
// Module : sort4_stream_ctrl_pkg
// Brief  : Shared types and constants for the 4-element streaming sorter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sort4_stream_ctrl_pkg;

    localparam int         c_DATA_W     = 8;
    localparam int         c_GROUP_SIZE = 4;
    localparam logic [7:0] c_PAD_ASC    = 8'hFF;
    localparam logic [7:0] c_PAD_DESC   = 8'h00;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sort4_stream_ctrl_if.sv
// ============================================================================
// Module : sort4_stream_ctrl_if
// Brief  : Upstream/downstream valid-ready streams plus busy status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sort4_stream_ctrl_if
    import sort4_stream_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    // Environment side: produces elements and consumes sorted results
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/sort4_stream_ctrl_sort4.sv
// ============================================================================
// Module : sort4
// Brief  : Combinational 4-input sorting network, ascending y0 <= ... <= y3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort4
    import sort4_stream_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
)(
    input  wire logic [DATA_W-1:0] x0,
    input  wire logic [DATA_W-1:0] x1,
    input  wire logic [DATA_W-1:0] x2,
    input  wire logic [DATA_W-1:0] x3,
    output logic      [DATA_W-1:0] y0,
    output logic      [DATA_W-1:0] y1,
    output logic      [DATA_W-1:0] y2,
    output logic      [DATA_W-1:0] y3
);

    logic [DATA_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [DATA_W-1:0] w_b0, w_b1, w_b2, w_b3;

    // Five compare-exchanges: pairs, cross min/max, then middle fix-up
    always_comb begin
        w_a0 = (x0 < x1) ? x0 : x1;
        w_a1 = (x0 < x1) ? x1 : x0;
        w_a2 = (x2 < x3) ? x2 : x3;
        w_a3 = (x2 < x3) ? x3 : x2;

        w_b0 = (w_a0 < w_a2) ? w_a0 : w_a2;
        w_b2 = (w_a0 < w_a2) ? w_a2 : w_a0;
        w_b1 = (w_a1 < w_a3) ? w_a1 : w_a3;
        w_b3 = (w_a1 < w_a3) ? w_a3 : w_a1;

        y0 = w_b0;
        y1 = (w_b1 < w_b2) ? w_b1 : w_b2;
        y2 = (w_b1 < w_b2) ? w_b2 : w_b1;
        y3 = w_b3;
    end

endmodule

`default_nettype wire

// File: rtl/sort4_stream_ctrl.sv
// ============================================================================
// Module : sort4_stream_ctrl
// Brief  : Collects groups of 1..4 elements, sorts them, streams them out.
//          Define SORT4_DESCEND_EN for descending output with zero padding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort4_stream_ctrl
    import sort4_stream_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    sort4_stream_ctrl_if.slave bus
);

`ifdef SORT4_DESCEND_EN
    localparam logic [DATA_W-1:0] c_PAD = DATA_W'(c_PAD_DESC);
`else
    localparam logic [DATA_W-1:0] c_PAD = DATA_W'(c_PAD_ASC);
`endif

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_cnt;
    logic [1:0]        r_idx;
    logic [2:0]        r_n;
    logic [DATA_W-1:0] r_slot   [c_GROUP_SIZE];
    logic [DATA_W-1:0] r_result [c_GROUP_SIZE];
    logic [DATA_W-1:0] w_y      [c_GROUP_SIZE];

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_out_last;
    logic              w_busy;
    logic [DATA_W-1:0] w_out_data;
    logic [1:0]        w_sel;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_grp_end;
    logic              w_out_end;

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;
    assign w_grp_end  = w_in_fire & (bus.in_last | (r_cnt == 2'd3));
    assign w_out_end  = w_out_fire & w_out_last;

`ifdef SORT4_DESCEND_EN
    assign w_sel = 2'd3 - r_idx;
`else
    assign w_sel = r_idx;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD:  if (w_grp_end) w_next_state = ST_SORT;
            ST_SORT:  w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_out_end) w_next_state = ST_LOAD;
            default:  w_next_state = ST_LOAD;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_out_data  = '0;
        w_busy      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = 1'b1;
            end
            ST_SORT: begin
                w_busy = 1'b1;
            end
            ST_DRAIN: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                w_out_data  = r_result[w_sel];
                w_out_last  = ({1'b0, r_idx} == (r_n - 3'd1));
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = w_busy;

    // ---------------- group bookkeeping ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_n   <= 3'd0;
            r_idx <= 2'd0;
        end else begin
            if (w_grp_end) begin
                r_cnt <= 2'd0;
                r_n   <= {1'b0, r_cnt} + 3'd1;
            end else if (w_in_fire) begin
                r_cnt <= r_cnt + 2'd1;
            end

            if (w_out_end) begin
                r_idx <= 2'd0;
            end else if (w_out_fire) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Every slot is rewritten each group (data or pad), so no stale values leak
    for (genvar i = 0; i < c_GROUP_SIZE; i++) begin : g_slot
        localparam logic [1:0] c_SLOT = 2'(i);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot[i] <= '0;
            end else if (w_in_fire && (r_cnt == c_SLOT)) begin
                r_slot[i] <= bus.in_data;
            end else if (w_grp_end && (c_SLOT > r_cnt)) begin
                r_slot[i] <= c_PAD;
            end
        end
    end

    sort4 #(
        .DATA_W (DATA_W)
    ) u_sort4 (
        .x0 (r_slot[0]),
        .x1 (r_slot[1]),
        .x2 (r_slot[2]),
        .x3 (r_slot[3]),
        .y0 (w_y[0]),
        .y1 (w_y[1]),
        .y2 (w_y[2]),
        .y3 (w_y[3])
    );

    for (genvar i = 0; i < c_GROUP_SIZE; i++) begin : g_result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_result[i] <= '0;
            end else if (r_state == ST_SORT) begin
                r_result[i] <= w_y[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sort4_stream_ctrl.sv
// ============================================================================
// Module : tb_sort4_stream_ctrl
// Brief  : Directed self-checking bench for sort4_stream_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sort4_stream_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_bad;

    sort4_stream_ctrl_if #(.DATA_W(8)) bus ();

    sort4_stream_ctrl #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one element; returns #1 after the edge that takes it
    task automatic send(input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    // Wait (bounded) for out_valid, report what is presented, then take it
    task automatic recv(output logic [7:0] d, output logic l, output bit to);
        int k;
        k  = 0;
        to = 1'b0;
        while (!bus.out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.out_valid) to = 1'b1;
        d = bus.out_data;
        l = bus.out_last;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.out_last !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d last=%b busy=%b want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_full_group();
        logic [7:0] exp [4];
        logic [7:0] d;
        logic       l;
        bit         to;
        int         lat;
`ifdef SORT4_DESCEND_EN
        exp = '{8'd4, 8'd3, 8'd2, 8'd1};
`else
        exp = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
        send(8'd4, 1'b0);
        send(8'd3, 1'b0);
        send(8'd2, 1'b0);
        send(8'd1, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_sort_state: got rdy=%b busy=%b want 0 1", bus.in_ready, bus.busy);
        end
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL full_latency: got %0d cycles want 2", lat);
        end
        for (int i = 0; i < 4; i++) begin
            recv(d, l, to);
            n_checks++;
            if (to || d !== exp[i] || l !== (i == 3)) begin
                n_bad++;
                $display("FAIL full_out[%0d]: got data=%0d last=%b timeout=%0d want data=%0d last=%b",
                         i, d, l, to, exp[i], (i == 3));
            end
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_back_to_load: got vld=%b rdy=%b busy=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4];
        logic [7:0] d;
        logic       l;
        bit         to;
`ifdef SORT4_DESCEND_EN
        exp = '{8'd92, 8'd25, 8'd8, 8'd3};
`else
        exp = '{8'd3, 8'd8, 8'd25, 8'd92};
`endif
        send(8'd25, 1'b0);
        send(8'd92, 1'b0);
        send(8'd3, 1'b0);
        send(8'd8, 1'b1);
        recv(d, l, to);
        n_checks++;
        if (to || d !== exp[0] || l !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_out[0]: got data=%0d last=%b timeout=%0d want %0d 0", d, l, to, exp[0]);
        end
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp[1] || bus.out_last !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got vld=%b data=%0d last=%b want 1 %0d 0",
                         c, bus.out_valid, bus.out_data, bus.out_last, exp[1]);
            end
            @(posedge clk); #1;
        end
        for (int i = 1; i < 4; i++) begin
            recv(d, l, to);
            n_checks++;
            if (to || d !== exp[i] || l !== (i == 3)) begin
                n_bad++;
                $display("FAIL stall_out[%0d]: got data=%0d last=%b timeout=%0d want data=%0d last=%b",
                         i, d, l, to, exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_partial();
        logic [7:0] exp2 [2];
        logic [7:0] exp4 [4];
        logic [7:0] d;
        logic       l;
        bit         to;
`ifdef SORT4_DESCEND_EN
        exp2 = '{8'd32, 8'd0};
        exp4 = '{8'd4, 8'd3, 8'd2, 8'd1};
`else
        exp2 = '{8'd0, 8'd32};
        exp4 = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
        send(8'd32, 1'b0);
        send(8'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            recv(d, l, to);
            n_checks++;
            if (to || d !== exp2[i] || l !== (i == 1)) begin
                n_bad++;
                $display("FAIL partial_out[%0d]: got data=%0d last=%b timeout=%0d want data=%0d last=%b",
                         i, d, l, to, exp2[i], (i == 1));
            end
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_no_pad: got vld=%b data=%0d rdy=%b want vld=0 rdy=1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        send(8'd1, 1'b0);
        send(8'd4, 1'b0);
        send(8'd3, 1'b0);
        send(8'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            recv(d, l, to);
            n_checks++;
            if (to || d !== exp4[i] || l !== (i == 3)) begin
                n_bad++;
                $display("FAIL partial_next[%0d]: got data=%0d last=%b timeout=%0d want data=%0d last=%b",
                         i, d, l, to, exp4[i], (i == 3));
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic       l;
        bit         to;
        send(8'd79, 1'b1);
        bus.out_ready = 1'b0;
        // Offer elements while the controller is busy; none may be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd200;
        bus.in_last  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy: got rdy=%b vld=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        recv(d, l, to);
        n_checks++;
        if (to || d !== 8'd79 || l !== 1'b1) begin
            n_bad++;
            $display("FAIL single_out: got data=%0d last=%b timeout=%0d want 79 1", d, l, to);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_done: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        send(8'd6, 1'b1);
        recv(d, l, to);
        n_checks++;
        if (to || d !== 8'd6 || l !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ignored: got data=%0d last=%b timeout=%0d want 6 1", d, l, to);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] exp [4];
        logic [7:0] d;
        logic       l;
        bit         to;
`ifdef SORT4_DESCEND_EN
        exp = '{8'd79, 8'd64, 8'd32, 8'd0};
`else
        exp = '{8'd0, 8'd32, 8'd64, 8'd79};
`endif
        send(8'd4, 1'b0);
        send(8'd3, 1'b0);
        send(8'd2, 1'b0);
        send(8'd1, 1'b0);
        recv(d, l, to);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0 ||
            bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got vld=%b data=%0d last=%b busy=%b want 0 0 0 0",
                     bus.out_valid, bus.out_data, bus.out_last, bus.busy);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_release: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        send(8'd64, 1'b0);
        send(8'd0, 1'b0);
        send(8'd79, 1'b0);
        send(8'd32, 1'b1);
        for (int i = 0; i < 4; i++) begin
            recv(d, l, to);
            n_checks++;
            if (to || d !== exp[i] || l !== (i == 3)) begin
                n_bad++;
                $display("FAIL rst_mid_next[%0d]: got data=%0d last=%b timeout=%0d want data=%0d last=%b",
                         i, d, l, to, exp[i], (i == 3));
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_bad         = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        #2;
        test_reset();
        test_full_group();
        test_stall();
        test_partial();
        test_single();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
